spike_aer_encoder: RTL and testbench

//  Downstream of neuron_tile: takes the tile's per-neuron spike vector and emits one

---
 rtl/spike_aer_encoder_pkg.sv | 12 +
 rtl/spike_aer_encoder_if.sv | 37 +++
 rtl/spike_aer_encoder_fifo.sv | 57 +++++
 rtl/spike_aer_encoder.sv | 94 +++++++++
 tb/tb_spike_aer_encoder.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_aer_encoder_pkg.sv
// Shared types and default sizing for the spike-to-AER encoder slice.
//   encState_e     : encoder FSM state (idle / scanning a captured vector)
//   Def*           : default parameter values used by the interface and the top
package spike_aer_encoder_pkg;

  typedef enum logic {StIdle, StScan} encState_e;

  localparam int unsigned DefSizeTile    = 4;
  localparam int unsigned DefSizeAddress = 4;
  localparam int unsigned DefFifoDepth   = 8;

endpackage

// File: rtl/spike_aer_encoder_if.sv
// Bundle of all handshake/bus signals of the spike AER encoder.
//   spikeIn/spikeValid/tileBase -> spike vector producer side (spikeAccept back)
//   aerAddr/aerValid            -> event stream to the router (aerReady back)
//   fifoCount/busy              -> status
// modport slave is the encoder's view, modport master the surrounding system's view.
interface spike_aer_encoder_if
  import spike_aer_encoder_pkg::*;
#(
  parameter int unsigned SizeTile    = DefSizeTile,
  parameter int unsigned SizeAddress = DefSizeAddress,
  parameter int unsigned FifoDepth   = DefFifoDepth
);
  localparam int unsigned SizeIdx    = $clog2(SizeTile);
  localparam int unsigned SizeAer    = SizeAddress + SizeIdx;
  localparam int unsigned CountWidth = $clog2(FifoDepth) + 1;

  logic [SizeTile-1:0]    spikeIn;
  logic                   spikeValid;
  logic [SizeAddress-1:0] tileBase;
  logic                   spikeAccept;
  logic [SizeAer-1:0]     aerAddr;
  logic                   aerValid;
  logic                   aerReady;
  logic [CountWidth-1:0]  fifoCount;
  logic                   busy;

  modport master (
    output spikeIn, spikeValid, tileBase, aerReady,
    input  spikeAccept, aerAddr, aerValid, fifoCount, busy
  );

  modport slave (
    input  spikeIn, spikeValid, tileBase, aerReady,
    output spikeAccept, aerAddr, aerValid, fifoCount, busy
  );

endinterface

// File: rtl/spike_aer_encoder_fifo.sv
// Show-ahead FIFO holding encoded address events.
//   clk, reset      : clock, synchronous active-high reset (empties and clears storage)
//   push, pushData  : write request; ignored while full (no push-through on full)
//   pop, popData    : read request; popData is the head entry, stable while empty
//   full, empty     : occupancy flags derived from the registered count
//   count           : current occupancy, 0..Depth
module spike_aer_encoder_fifo #(
  parameter int unsigned Width = 6,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [Width-1:0]           pushData,
  input  logic                       pop,
  output logic [Width-1:0]           popData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth):0]     count
);
  localparam int unsigned PtrWidth   = $clog2(Depth);
  localparam int unsigned CountWidth = PtrWidth + 1;

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wrPtr;
  logic [PtrWidth-1:0] rdPtr;
  logic                doPush;
  logic                doPop;

  assign full    = (count == CountWidth'(Depth));
  assign empty   = (count == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];

  // Depth is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + PtrWidth'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PtrWidth'(1);
      end
      count <= count + CountWidth'(doPush) - CountWidth'(doPop);
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike vector to address-event encoder.
// Captures a per-neuron spike vector from a tile and emits one event {tileBase, neuron idx}
// per set bit, lowest index first, through an internal FIFO toward the router.
//   clk, reset : clock, synchronous active-high reset
//   bus        : spike_aer_encoder_if.slave (spike input, AER output, fifoCount, busy)
module spike_aer_encoder
  import spike_aer_encoder_pkg::*;
#(
  parameter int unsigned SizeTile    = DefSizeTile,
  parameter int unsigned SizeAddress = DefSizeAddress,
  parameter int unsigned FifoDepth   = DefFifoDepth
) (
  input  logic                 clk,
  input  logic                 reset,
  spike_aer_encoder_if.slave   bus
);
  localparam int unsigned SizeIdx    = $clog2(SizeTile);
  localparam int unsigned SizeAer    = SizeAddress + SizeIdx;
  localparam int unsigned CountWidth = $clog2(FifoDepth) + 1;

  encState_e              state;
  logic [SizeTile-1:0]    pend;
  logic [SizeTile-1:0]    pendCleared;
  logic [SizeAddress-1:0] base;
  logic                   push;
  logic                   pop;
  logic [SizeAer-1:0]     pushData;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic [CountWidth-1:0]  count;

  function automatic logic [SizeIdx-1:0] lowestSetIdx(input logic [SizeTile-1:0] vec);
    logic [SizeIdx-1:0] idx;
    idx = '0;
    for (int i = SizeTile - 1; i >= 0; i--) begin
      if (vec[i]) idx = SizeIdx'(i);
    end
    return idx;
  endfunction

  // x & (x-1) drops the lowest set bit, i.e. the one being pushed this cycle.
  assign pendCleared = pend & (pend - SizeTile'(1));
  assign push        = (state == StScan) && !fifoFull;
  assign pushData    = {base, lowestSetIdx(pend)};
  assign pop         = !fifoEmpty && bus.aerReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= StIdle;
      pend  <= '0;
      base  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.spikeValid) begin
            pend <= bus.spikeIn;
            base <= bus.tileBase;
            // An all-zero vector is consumed without producing events.
            if (|bus.spikeIn) state <= StScan;
          end
        end
        StScan: begin
          // A full FIFO stalls the scan; nothing is dropped.
          if (!fifoFull) begin
            pend <= pendCleared;
            if (pendCleared == '0) state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  spike_aer_encoder_fifo #(
    .Width (SizeAer),
    .Depth (FifoDepth)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushData (pushData),
    .pop      (pop),
    .popData  (bus.aerAddr),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (count)
  );

  assign bus.spikeAccept = (state == StIdle);
  assign bus.aerValid    = !fifoEmpty;
  assign bus.fifoCount   = count;
  assign bus.busy        = (state == StScan) || !fifoEmpty;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Self-checking bench for spike_aer_encoder: vector table, scoreboard of expected events,
// and a cycle model of occupancy/handshake status.
module tb_spike_aer_encoder;
  localparam int unsigned SizeTile    = 4;
  localparam int unsigned SizeAddress = 4;
  localparam int unsigned FifoDepth   = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spike_aer_encoder_if #(
    .SizeTile    (SizeTile),
    .SizeAddress (SizeAddress),
    .FifoDepth   (FifoDepth)
  ) bus ();

  spike_aer_encoder #(
    .SizeTile    (SizeTile),
    .SizeAddress (SizeAddress),
    .FifoDepth   (FifoDepth)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard, evaluated at the falling edge.
  bit         modelValid = 1'b0;
  bit         mScan;
  logic [3:0] mPend;
  int         mCount;
  logic [5:0] sbQ[$];
  logic [5:0] seen[$];
  int         hsCount   = 0;
  int         peakCount = 0;

  always @(negedge clk) begin : monitor
    bit mPush;
    bit mPop;
    bit hs;
    if (reset) begin
      modelValid = 1'b1;
      mScan      = 1'b0;
      mPend      = '0;
      mCount     = 0;
      sbQ.delete();
    end else if (modelValid) begin
      check("fifoCount", bus.fifoCount, mCount);
      check("aerValid", bus.aerValid, mCount != 0);
      check("spikeAccept", bus.spikeAccept, !mScan);
      check("busy", bus.busy, mScan || (mCount != 0));
      if (int'(bus.fifoCount) > peakCount) peakCount = int'(bus.fifoCount);
      if (bus.aerValid && bus.aerReady) begin
        if (sbQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("FAIL unexpectedEvent: got 0x%0h, expected no event", bus.aerAddr);
        end else begin
          check("aerAddr", bus.aerAddr, sbQ.pop_front());
        end
        seen.push_back(bus.aerAddr);
      end
      mPop  = (mCount != 0) && bus.aerReady;
      mPush = mScan && (mCount != FifoDepth);
      hs    = !mScan && bus.spikeValid;
      if (hs) begin
        hsCount++;
        for (int i = 0; i < SizeTile; i++) begin
          if (bus.spikeIn[i]) sbQ.push_back({bus.tileBase, 2'(i)});
        end
      end
      mCount = mCount + int'(mPush) - int'(mPop);
      if (mPush) begin
        for (int i = 0; i < SizeTile; i++) begin
          if (mPend[i]) begin
            mPend[i] = 1'b0;
            break;
          end
        end
        if (mPend == '0) mScan = 1'b0;
      end else if (hs) begin
        mPend = bus.spikeIn;
        mScan = (bus.spikeIn != '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic sendVector(input logic [3:0] v, input logic [3:0] b);
    int n = 0;
    bus.spikeValid = 1'b1;
    bus.spikeIn    = v;
    bus.tileBase   = b;
    @(negedge clk);
    while (!bus.spikeAccept && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      nCompared++;
      nMismatched++;
      $display("FAIL acceptTimeout: got spikeAccept=0, expected 1 within 400 cycles");
    end
    tick();
    bus.spikeValid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      nCompared++;
      nMismatched++;
      $display("FAIL drainTimeout: got busy=1, expected 0 within 400 cycles");
    end
    tick();
  endtask

  typedef struct {
    logic [3:0] spikeIn;
    logic [3:0] tileBase;
    int         expNum;
    logic [5:0] expFirst;
    logic [5:0] expLast;
  } vec_t;

  vec_t tbl[6];
  bit   stimDone;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin : main
    tbl[0] = '{4'b1010, 4'd3,  2, {4'd3, 2'd1},  {4'd3, 2'd3}};
    tbl[1] = '{4'b0000, 4'd5,  0, 6'd0,          6'd0};
    tbl[2] = '{4'b0001, 4'd0,  1, {4'd0, 2'd0},  {4'd0, 2'd0}};
    tbl[3] = '{4'b1000, 4'd15, 1, {4'd15, 2'd3}, {4'd15, 2'd3}};
    tbl[4] = '{4'b1111, 4'd9,  4, {4'd9, 2'd0},  {4'd9, 2'd3}};
    tbl[5] = '{4'b0110, 4'd6,  2, {4'd6, 2'd1},  {4'd6, 2'd2}};

    bus.spikeValid = 1'b0;
    bus.spikeIn    = '0;
    bus.tileBase   = '0;
    bus.aerReady   = 1'b1;
    reset          = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("resetAccept", bus.spikeAccept, 1'b1);
    check("resetAerValid", bus.aerValid, 1'b0);
    check("resetCount", bus.fifoCount, 0);
    check("resetBusy", bus.busy, 1'b0);
    check("resetAddr", bus.aerAddr, 0);

    // Table of single vectors, no backpressure.
    for (int t = 0; t < 6; t++) begin
      seen.delete();
      peakCount = 0;
      sendVector(tbl[t].spikeIn, tbl[t].tileBase);
      check("acceptAfterHs", bus.spikeAccept, tbl[t].expNum == 0);
      check("aerValidAfterHs", bus.aerValid, 1'b0);
      waitDrain();
      check("numEvents", seen.size(), tbl[t].expNum);
      if (seen.size() > 0 && tbl[t].expNum > 0) begin
        check("firstEvent", seen[0], tbl[t].expFirst);
        check("lastEvent", seen[seen.size()-1], tbl[t].expLast);
      end
      if (t == 0) check("peakCount", peakCount, 1);
    end

    // Fill to full and stall, then release.
    seen.delete();
    bus.aerReady = 1'b0;
    for (int b = 0; b < 3; b++) sendVector(4'b1111, 4'(b));
    repeat (5) tick();
    check("fullCount", bus.fifoCount, FifoDepth);
    check("stallAccept", bus.spikeAccept, 1'b0);
    check("stallBusy", bus.busy, 1'b1);
    bus.aerReady = 1'b1;
    sendVector(4'b1111, 4'd3);
    waitDrain();
    check("stallEvents", seen.size(), 16);
    for (int i = 0; i < 16 && i < seen.size(); i++) begin
      check("stallOrder", seen[i], {4'(i / 4), 2'(i % 4)});
    end

    // Random backpressure with continuous vectors.
    seen.delete();
    stimDone = 1'b0;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          sendVector((k % 3 == 0) ? 4'b1111 : 4'($urandom_range(1, 15)), 4'(k));
        end
        stimDone = 1'b1;
      end
      begin
        int guard = 0;
        while (!stimDone && guard < 3000) begin
          @(posedge clk);
          #1;
          bus.aerReady = 1'($urandom_range(0, 1));
          guard++;
        end
      end
    join
    bus.aerReady = 1'b1;
    waitDrain();
    check("wrapEvents", seen.size() >= 24, 1'b1);
    check("randomSbEmpty", sbQ.size(), 0);

    // Reset with a scan in flight and five events queued.
    bus.aerReady = 1'b0;
    sendVector(4'b1111, 4'd1);
    sendVector(4'b1111, 4'd2);
    begin
      int n = 0;
      while (bus.fifoCount != 5 && n < 50) begin
        tick();
        n++;
      end
    end
    check("preResetCount", bus.fifoCount, 5);
    check("preResetScan", bus.spikeAccept, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("postResetAerValid", bus.aerValid, 1'b0);
    check("postResetCount", bus.fifoCount, 0);
    check("postResetBusy", bus.busy, 1'b0);
    check("postResetAccept", bus.spikeAccept, 1'b1);
    bus.aerReady = 1'b1;
    tick();

    // spikeValid held high: one capture per handshake.
    seen.delete();
    hsCount = 0;
    bus.spikeValid = 1'b1;
    bus.spikeIn    = 4'b1011;
    bus.tileBase   = 4'd7;
    repeat (12) tick();
    bus.spikeValid = 1'b0;
    waitDrain();
    check("heldHandshakes", hsCount, 3);
    check("heldEvents", seen.size(), 9);
    check("finalSbEmpty", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
